// File: rtl/operand_memory.sv
// Operand buffer between the input stream and the calculation stage: fills from
// the stream while the controller is in mem, then drains in order during cal.
module operand_memory #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             state,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [DW-1:0]          out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             MS,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_CAL  = 2'd2;

  localparam logic [1:0] MS_IDLE    = 2'b00;
  localparam logic [1:0] MS_READY   = 2'b01;
  localparam logic [1:0] MS_LOADED  = 2'b10;
  localparam logic [1:0] MS_DRAINED = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_FILL,
    S_LOADED,
    S_DRAIN,
    S_DONE
  } fsm_t;

  fsm_t            fsm_q, fsm_d;
  logic [AW-1:0]   wr_ptr, wr_ptr_d;
  logic [AW-1:0]   rd_ptr, rd_ptr_d;
  logic [CW-1:0]   count_d;
  logic            in_ready_d;
  logic            out_valid_d;
  logic [1:0]      ms_d;
  logic            wr_en;
  logic [DW-1:0]   mem [DEPTH];

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      MS        <= MS_IDLE;
    end else begin
      fsm_q     <= fsm_d;
      wr_ptr    <= wr_ptr_d;
      rd_ptr    <= rd_ptr_d;
      count     <= count_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      MS        <= ms_d;
    end
  end

  // Operand storage; contents survive reset and are tracked only by pointers
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  assign out_data = mem[rd_ptr];

  // Next-state, pointer and output logic
  always_comb begin
    fsm_d       = fsm_q;
    wr_ptr_d    = wr_ptr;
    rd_ptr_d    = rd_ptr;
    count_d     = count;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    wr_en       = 1'b0;

    case (fsm_q)
      S_IDLE: fsm_d = S_READY;

      S_READY: begin
        if (state == ST_MEM) begin
          fsm_d      = S_FILL;
          in_ready_d = (count < CW'(DEPTH));
        end
      end

      S_FILL: begin
        if (state != ST_INIT) begin
          if (in_valid && in_ready) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr + AW'(1);
            count_d  = count + CW'(1);
          end
          in_ready_d = (count_d < CW'(DEPTH));
          // The accepted operand is already stored when the block reports loaded
          if (wr_en && (in_last || count_d == CW'(DEPTH))) begin
            fsm_d      = S_LOADED;
            in_ready_d = 1'b0;
          end
        end
      end

      S_LOADED: begin
        if (state == ST_CAL) begin
          fsm_d       = S_DRAIN;
          out_valid_d = (count != '0);
        end
      end

      S_DRAIN: begin
        if (state != ST_INIT) begin
          out_valid_d = (count != '0);
          if (out_valid && out_ready) begin
            rd_ptr_d = rd_ptr + AW'(1);
            count_d  = count - CW'(1);
            if (count_d == '0) begin
              fsm_d       = S_DONE;
              out_valid_d = 1'b0;
            end
          end
        end
      end

      S_DONE: ;

      default: fsm_d = S_IDLE;
    endcase

    // Controller restart from any active state
    if (state == ST_INIT && fsm_q inside {S_FILL, S_LOADED, S_DRAIN, S_DONE}) begin
      fsm_d       = S_READY;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      wr_en       = 1'b0;
    end

    case (fsm_d)
      S_IDLE:                ms_d = MS_IDLE;
      S_READY, S_FILL:       ms_d = MS_READY;
      S_LOADED, S_DRAIN:     ms_d = MS_LOADED;
      S_DONE:                ms_d = MS_DRAINED;
      default:               ms_d = MS_IDLE;
    endcase
  end

endmodule

// File: tb/tb_operand_memory.sv
// Self-checking bench for operand_memory: scenario tasks against a queue model.
module tb_operand_memory;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    state;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    MS;
  logic [CW-1:0] count;

  int n_total = 0;
  int n_pass  = 0;
  logic [DW-1:0] q[$];

  operand_memory #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .state(state),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .MS(MS), .count(count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One input cycle; acc tells whether the block takes the operand at the edge
  task automatic push(input logic [DW-1:0] d, input logic v, input logic l, output logic acc);
    in_data  = d;
    in_valid = v;
    in_last  = l;
    acc      = v && in_ready;
    cyc();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // One output cycle; reports what was presented and whether it transferred
  task automatic step_drain(input logic rdy, output logic v, output logic xfer,
                            output logic [DW-1:0] d);
    out_ready = rdy;
    v         = out_valid;
    d         = out_data;
    xfer      = out_valid && rdy;
    cyc();
    out_ready = 1'b0;
  endtask

  // Back to READY, then enter FILL
  task automatic begin_fill();
    state = 2'd0;
    cyc();
    state = 2'd1;
    cyc();
    q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; state = 2'd0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (MS !== 2'b00) $display("FAIL reset_ms got %0d want 0", MS); else n_pass++;
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || count !== '0)
      $display("FAIL reset_outs got ov=%0b ir=%0b cnt=%0d want 0/0/0", out_valid, in_ready, count);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (MS !== 2'b00) $display("FAIL release_ms0 got %0d want 0", MS); else n_pass++;
    #3;
    cyc();
    n_total++; if (MS !== 2'b01 || in_ready !== 1'b0 || count !== '0)
      $display("FAIL release_ready got ms=%0d ir=%0b cnt=%0d want 1/0/0", MS, in_ready, count);
    else n_pass++;
    state = 2'd2;
    cyc();
    n_total++; if (MS !== 2'b01 || out_valid !== 1'b0)
      $display("FAIL ready_ignores_cal got ms=%0d ov=%0b want 1/0", MS, out_valid);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic acc, v, x;
    logic [DW-1:0] d;
    logic [DW-1:0] vals [3] = '{8'd3, 8'd5, 8'd7};
    begin_fill();
    n_total++; if (in_ready !== 1'b1) $display("FAIL fill_ready got %0b want 1", in_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      push(vals[i], 1'b1, i == 2, acc);
      if (acc) q.push_back(vals[i]);
    end
    n_total++; if (count !== CW'(3) || in_ready !== 1'b0 || MS !== 2'b10)
      $display("FAIL basic_loaded got cnt=%0d ir=%0b ms=%0d want 3/0/2", count, in_ready, MS);
    else n_pass++;
    state = 2'd2;
    cyc();
    for (int t = 0; t < 20 && q.size() > 0; t++) begin
      step_drain(1'b1, v, x, d);
      if (x) begin
        n_total++; if (d !== q[0]) $display("FAIL basic_data got %0d want %0d", d, q[0]); else n_pass++;
        void'(q.pop_front());
      end
    end
    n_total++; if (q.size() != 0) $display("FAIL basic_drain_timeout left %0d want 0", q.size()); else n_pass++;
    n_total++; if (MS !== 2'b11 || out_valid !== 1'b0)
      $display("FAIL basic_done got ms=%0d ov=%0b want 3/0", MS, out_valid);
    else n_pass++;
  endtask

  task automatic test_full();
    logic acc, v, x;
    logic [DW-1:0] d;
    begin_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      push(DW'(i), 1'b1, 1'b0, acc);
      if (acc) q.push_back(DW'(i));
    end
    n_total++; if (MS !== 2'b10 || count !== CW'(DEPTH) || in_ready !== 1'b0)
      $display("FAIL full_loaded got ms=%0d cnt=%0d ir=%0b want 2/%0d/0", MS, count, in_ready, DEPTH);
    else n_pass++;
    push(8'd99, 1'b1, 1'b1, acc);
    n_total++; if (acc !== 1'b0 || count !== CW'(DEPTH))
      $display("FAIL full_overflow got acc=%0b cnt=%0d want 0/%0d", acc, count, DEPTH);
    else n_pass++;
    state = 2'd2;
    cyc();
    for (int t = 0; t < 40 && q.size() > 0; t++) begin
      step_drain(1'b1, v, x, d);
      if (x) begin
        n_total++; if (d !== q[0]) $display("FAIL full_data got %0d want %0d", d, q[0]); else n_pass++;
        void'(q.pop_front());
      end
    end
    n_total++; if (q.size() != 0 || MS !== 2'b11)
      $display("FAIL full_done got left=%0d ms=%0d want 0/3", q.size(), MS);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic acc, v, x, held_v;
    logic [DW-1:0] d, held_d, r;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    begin_fill();
    for (int i = 0; i < 5; i++) begin
      r = DW'($urandom);
      push(r, 1'b1, i == 4, acc);
      if (acc) q.push_back(r);
    end
    state = 2'd2;
    cyc();
    held_v = 1'b0;
    held_d = '0;
    for (int t = 0; t < 60 && q.size() > 0; t++) begin
      step_drain(pat[t % 4], v, x, d);
      if (held_v && v) begin
        n_total++; if (d !== held_d) $display("FAIL bp_stable got %0d want %0d", d, held_d); else n_pass++;
      end
      held_v = v && !x;
      held_d = d;
      if (x) begin
        n_total++; if (d !== q[0]) $display("FAIL bp_data got %0d want %0d", d, q[0]); else n_pass++;
        void'(q.pop_front());
      end
    end
    n_total++; if (q.size() != 0 || MS !== 2'b11 || out_valid !== 1'b0)
      $display("FAIL bp_done got left=%0d ms=%0d ov=%0b want 0/3/0", q.size(), MS, out_valid);
    else n_pass++;
  endtask

  task automatic test_rounds();
    logic acc, v, x;
    logic [DW-1:0] d, r;
    for (int rnd = 0; rnd < 2; rnd++) begin
      begin_fill();
      n_total++; if (MS !== 2'b01) $display("FAIL round_ms_ready got %0d want 1", MS); else n_pass++;
      for (int i = 0; i < DEPTH; i++) begin
        r = DW'($urandom);
        push(r, 1'b1, 1'b0, acc);
        if (acc) q.push_back(r);
      end
      n_total++; if (MS !== 2'b10) $display("FAIL round_ms_loaded got %0d want 2", MS); else n_pass++;
      state = 2'd2;
      cyc();
      for (int t = 0; t < 60 && q.size() > 0; t++) begin
        step_drain(1'($urandom_range(0, 1)), v, x, d);
        if (x) begin
          n_total++; if (d !== q[0]) $display("FAIL round_data got %0d want %0d", d, q[0]); else n_pass++;
          void'(q.pop_front());
        end
      end
      state = 2'd3;
      cyc();
      n_total++; if (q.size() != 0 || MS !== 2'b11)
        $display("FAIL round_ms_done got left=%0d ms=%0d want 0/3", q.size(), MS);
      else n_pass++;
      state = 2'd0;
      cyc();
      n_total++; if (MS !== 2'b01 || count !== '0)
        $display("FAIL round_restart got ms=%0d cnt=%0d want 1/0", MS, count);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic acc, v, x, loaded, try_v, try_l;
    logic [DW-1:0] d, r;
    int n;
    for (int rnd = 0; rnd < 6; rnd++) begin
      n = $urandom_range(1, DEPTH);
      begin_fill();
      loaded = 1'b0;
      for (int t = 0; t < 100 && !loaded; t++) begin
        n_total++; if (in_ready !== 1'b1) $display("FAIL rand_ready got %0b want 1", in_ready); else n_pass++;
        try_v = 1'($urandom_range(0, 1));
        try_l = try_v ? (q.size() == n - 1) : 1'($urandom_range(0, 1));
        r = DW'($urandom);
        push(r, try_v, try_l, acc);
        if (acc) begin
          q.push_back(r);
          loaded = try_l || (q.size() == DEPTH);
        end
      end
      n_total++; if (MS !== 2'b10 || count !== CW'(q.size()) || in_ready !== 1'b0)
        $display("FAIL rand_loaded got ms=%0d cnt=%0d ir=%0b want 2/%0d/0", MS, count, in_ready, q.size());
      else n_pass++;
      state = 2'd2;
      cyc();
      for (int t = 0; t < 100 && q.size() > 0; t++) begin
        step_drain(1'($urandom_range(0, 1)), v, x, d);
        if (x) begin
          n_total++; if (d !== q[0]) $display("FAIL rand_data got %0d want %0d", d, q[0]); else n_pass++;
          void'(q.pop_front());
        end
      end
      n_total++; if (q.size() != 0 || MS !== 2'b11)
        $display("FAIL rand_done got left=%0d ms=%0d want 0/3", q.size(), MS);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_drain();
    logic acc, v, x;
    logic [DW-1:0] d;
    begin_fill();
    for (int i = 0; i < 4; i++) push(DW'(10 + i), 1'b1, i == 3, acc);
    state = 2'd2;
    cyc();
    step_drain(1'b1, v, x, d);
    step_drain(1'b1, v, x, d);
    n_total++; if (count !== CW'(2) || out_valid !== 1'b1)
      $display("FAIL mid_drain_count got cnt=%0d ov=%0b want 2/1", count, out_valid);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (MS !== 2'b00 || out_valid !== 1'b0 || count !== '0)
      $display("FAIL async_reset got ms=%0d ov=%0b cnt=%0d want 0/0/0", MS, out_valid, count);
    else n_pass++;
    rst = 1'b1;
    cyc();
    cyc();
    n_total++; if (MS !== 2'b01 || out_valid !== 1'b0 || count !== '0)
      $display("FAIL post_reset got ms=%0d ov=%0b cnt=%0d want 1/0/0", MS, out_valid, count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_backpressure();
    test_rounds();
    test_random();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/operand_memory.md
OPERAND_MEMORY -- requirements
Module: operand_memory

Interface
REQ-001 SHALL provide parameter DW, default 8, operand data width in bits.
REQ-002 SHALL provide parameter DEPTH, default 8, operand storage entries (power of two, >=2).
REQ-003 SHALL provide: clk  input  1  sole clock, all state updates on posedge.
REQ-004 SHALL provide: rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide: state  input  2  system state from controller (0 init, 1 mem, 2 cal, 3 display).
REQ-006 SHALL provide: in_data  input  DW  operand to store.
REQ-007 SHALL provide: in_valid  input  1  in_data valid.
REQ-008 SHALL provide: in_last  input  1  qualifies the accepted operand as final.
REQ-009 SHALL provide: in_ready  output  1  block can accept an operand.
REQ-010 SHALL provide: out_data  output  DW  operand presented to calculation stage.
REQ-011 SHALL provide: out_valid  output  1  out_data valid.
REQ-012 SHALL provide: out_ready  input  1  calculation stage accepts out_data.
REQ-013 SHALL provide: MS  output  2  memory status (00 idle, 01 ready, 10 loaded, 11 drained).
REQ-014 SHALL provide: count  output  clog2(DEPTH)+1  entries currently held.

Function
REQ-015 SHALL implement internal FSM IDLE, READY, FILL, LOADED, DRAIN, DONE; MS 00 in IDLE, 01 in READY/FILL, 10 in LOADED, 11 in DONE and DRAIN shows 10.
REQ-016 SHALL leave IDLE for READY on the first clock edge after rst deasserts, regardless of state.
REQ-017 SHALL move READY->FILL when state==1; FILL drives in_ready=1 while count<DEPTH; in_ready=0 in all other FSM states.
REQ-018 SHALL write in_data into mem[wr_ptr] on in_valid&&in_ready, incrementing wr_ptr (mod DEPTH) and count the same edge.
REQ-019 SHALL move FILL->LOADED on the edge of an accepted write with in_last=1 or that makes count==DEPTH; MS=10 from the next cycle.
REQ-020 SHALL ignore in_last when no write is accepted, and ignore in_valid while in_ready=0 (no overflow possible).
REQ-021 SHALL move LOADED->DRAIN when state==2; state 0/1/3 in LOADED hold except REQ-025.
REQ-022 SHALL in DRAIN drive out_valid=1 while count>0 with out_data=mem[rd_ptr], held stable until out_valid&&out_ready.
REQ-023 SHALL on out_valid&&out_ready increment rd_ptr (mod DEPTH) and decrement count; transfer of the final entry moves DRAIN->DONE, out_valid=0 and MS=11 from the next cycle.
REQ-024 SHALL drive out_valid=0 in every state other than DRAIN; out_data is don't-care when out_valid=0.
REQ-025 SHALL on state==0 while in FILL, LOADED, DRAIN or DONE return to READY next edge, clearing wr_ptr, rd_ptr, count, out_valid, in_ready (controller restart).
REQ-026 SHALL in READY ignore state==2 and state==3; DONE holds MS=11 through state 2 and 3.
REQ-027 SHALL give write acceptance priority over the in_last/full transition check in the same cycle (the accepted operand is stored before LOADED).
REQ-028 SHALL register all outputs except out_data, which is a read of the registered rd_ptr entry.

Reset
REQ-029 SHALL on rst=0, asynchronously: FSM=IDLE, MS=00, count=0, wr_ptr=rd_ptr=0, in_ready=0, out_valid=0; storage contents need not be cleared.
REQ-030 SHALL accept a reset assertion in any FSM state, including mid-FILL and mid-DRAIN, discarding all held operands.

Verification
REQ-031 Release rst, state=0 -> MS=00 first cycle, MS=01 next, in_ready=0, count=0.
REQ-032 state=1, write 3,5,7 with in_last on 7 -> count=3, in_ready=0 after 7, MS=10; state=2 -> out_data 3,5,7 in order with out_ready=1, then MS=11, out_valid=0.
REQ-033 state=1, write DEPTH=8 operands 1..8, no in_last -> MS=10 after 8th, 9th in_valid ignored, count=8; drain returns 1..8.
REQ-034 Drain with out_ready toggling 1,0,0,1 -> out_data held stable while out_ready=0, no entry lost or duplicated.
REQ-035 Two full fill/drain rounds via state 0->1->2->3->0 -> pointers wrap, second round data correct, MS sequence 01,10,11,01.
REQ-036 Assert rst mid-DRAIN with count=2 -> MS=00, out_valid=0, count=0 immediately, without waiting for a clock edge.
